// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a fifo_sync instance in whole bursts of BURST_LEN
// beats and presents them as a valid/ready stream. The out_last flag marks
// the final beat of each burst. A flush level lets a short tail burst out.
module fifo_burst_reader #(
  parameter int DATA_W    = 8,
  parameter int FIFO_SIZE = 32,
  parameter int BURST_LEN = 8,
  parameter int BUF_DEPTH = 4,
  localparam int CNT_W    = $clog2(FIFO_SIZE) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data_rd,
  input  logic [CNT_W-1:0]  fifo_data_count,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int BC_W  = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [BC_W:0]    BUF_DEPTH_C = (BC_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_WAIT_LAST
  } state_t;

  state_t            state_q, state_d;
  logic              rd_en_q;
  logic              rd_last_q, rd_last_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  burst_size_q, burst_size_d;
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data_d [BUF_DEPTH];
  logic              buf_last_q [BUF_DEPTH];
  logic              buf_last_d [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BC_W-1:0]   buf_count_q, buf_count_d;

  logic [CNT_W-1:0]  avail;
  logic [BC_W:0]     buf_fill;
  logic              rd_en;
  logic              push;
  logic              pop;
  logic              head_last;

  // The FIFO count lags a read by one cycle, so subtract the read in flight.
  assign avail    = fifo_data_count - CNT_W'(rd_en_q);
  // Entries held plus the one about to land from the read issued last cycle.
  assign buf_fill = {1'b0, buf_count_q} + (BC_W + 1)'(rd_en_q);

  assign push      = rd_en_q;
  assign out_valid = (buf_count_q != '0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign head_last = buf_last_q[rd_ptr_q];
  assign out_last  = out_valid && head_last;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != S_IDLE);
  assign fifo_rd_en = rd_en;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Burst sequencing: pick the burst size in IDLE, issue reads in BURST, wait
  // for the tagged last beat to leave in WAIT_LAST.
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    burst_size_d = burst_size_q;
    rd_en        = 1'b0;
    rd_last_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (avail >= BURST_LEN_C) begin
          burst_size_d = BURST_LEN_C;
          issued_d     = '0;
          state_d      = S_BURST;
        end else if (flush && (avail != '0)) begin
          burst_size_d = avail;
          issued_d     = '0;
          state_d      = S_BURST;
        end
      end
      S_BURST: begin
        rd_en = (issued_q < burst_size_q) && (avail != '0) && (buf_fill < BUF_DEPTH_C);
        if (rd_en) begin
          issued_d  = issued_q + CNT_W'(1);
          rd_last_d = (issued_q == burst_size_q - CNT_W'(1));
        end
        if (issued_d == burst_size_q) begin
          state_d = S_WAIT_LAST;
        end
      end
      S_WAIT_LAST: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffer: capture returning read data, release the head on handshake.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_count_d = buf_count_q;
    if (push) begin
      buf_data_d[wr_ptr_q] = fifo_data_rd;
      buf_last_d[wr_ptr_q] = rd_last_q;
      wr_ptr_d             = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    if (push && !pop) begin
      buf_count_d = buf_count_q + BC_W'(1);
    end else if (!push && pop) begin
      buf_count_d = buf_count_q - BC_W'(1);
    end
  end

  // State and buffer registers; reset abandons any burst and drops reads in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rd_en_q      <= 1'b0;
      rd_last_q    <= 1'b0;
      issued_q     <= '0;
      burst_size_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      buf_count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en;
      rd_last_q    <= rd_last_d;
      issued_q     <= issued_d;
      burst_size_q <= burst_size_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      buf_count_q  <= buf_count_d;
      buf_data_q   <= buf_data_d;
      buf_last_q   <= buf_last_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: a queue-based FIFO with one-cycle read
// latency and a lagged count feeds the reader, and a transaction-level model
// predicts the stream (word order, burst boundaries, busy, valid timing).
module tb_fifo_burst_reader;

  localparam int DATA_W    = 8;
  localparam int FIFO_SIZE = 32;
  localparam int BURST_LEN = 8;
  localparam int BUF_DEPTH = 4;
  localparam int CNT_W     = $clog2(FIFO_SIZE) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data_rd = '0;
  logic [CNT_W-1:0]  fifo_data_count = '0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_W(DATA_W), .FIFO_SIZE(FIFO_SIZE), .BURST_LEN(BURST_LEN), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .fifo_rd_en(fifo_rd_en), .fifo_data_rd(fifo_data_rd),
    .fifo_data_count(fifo_data_count), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic              wr_req = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              rd_en_s = 1'b0;
  logic              tog = 1'b0;

  logic m_busy = 1'b0;
  int   m_size = 0, m_beat = 0, m_reads = 0;
  int   reads_total = 0, pops_total = 0;
  logic last_rd = 1'b0;
  logic rst_seen = 1'b0;
  logic stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  int   cyc = 0;
  int   rd_events = 0;
  logic [DATA_W-1:0] log_data[$];
  logic log_last[$];
  logic arm_lat = 1'b0;
  int   cyc_cnt_hit = -1, cyc_first_valid = -1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic logic readyFor(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin
      tog = ~tog;
      return tog;
    end
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic applyStimulus(input logic wr, input logic [DATA_W-1:0] d,
                               input logic rdy, input logic fl);
    wr_req    = wr;
    wr_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // FIFO stand-in: data one cycle after the read, count one further cycle late.
  always @(posedge clk) begin
    int occ;
    occ = fifo_q.size();
    if (rd_en_s) begin
      if (fifo_q.size() > 0) fifo_data_rd <= fifo_q.pop_front();
      else fifo_data_rd <= '0;
    end
    if (wr_req && fifo_q.size() < FIFO_SIZE) begin
      fifo_q.push_back(wr_data);
      exp_q.push_back(wr_data);
    end
    fifo_data_count <= CNT_W'(occ);
  end

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    logic hs;
    logic exp_valid;
    logic busy_n;
    cyc++;
    rd_en_s = fifo_rd_en;
    if (reset) begin
      rst_seen   = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (rst_seen) begin
        rst_seen = 1'b0;
        exp_q = fifo_q;
        m_busy = 1'b0; m_size = 0; m_beat = 0; m_reads = 0;
        reads_total = 0; pops_total = 0; last_rd = 1'b0;
      end
      hs = out_valid && out_ready;
      busy_n = m_busy;
      checkOutput("busy", int'(busy), int'(m_busy));
      exp_valid = (reads_total - int'(last_rd) - pops_total) > 0;
      checkOutput("out_valid", int'(out_valid), int'(exp_valid));
      if (out_valid) begin
        checkOutput("stream_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          checkOutput("out_data", int'(out_data), int'(exp_q[0]));
          checkOutput("out_last", int'(out_last), int'(m_beat == m_size - 1));
        end
      end
      if (stall_prev) begin
        checkOutput("stall_valid", int'(out_valid), 1);
        checkOutput("stall_data", int'(out_data), int'(prev_data));
        checkOutput("stall_last", int'(out_last), int'(prev_last));
      end
      if (arm_lat) begin
        if (cyc_cnt_hit < 0 && int'(fifo_data_count) >= BURST_LEN) cyc_cnt_hit = cyc;
        if (cyc_first_valid < 0 && out_valid) cyc_first_valid = cyc;
      end
      if (fifo_rd_en) begin
        checkOutput("rd_while_idle", int'(m_busy), 1);
        checkOutput("fifo_underflow", int'(fifo_q.size() > 0), 1);
        checkOutput("rd_past_burst", int'(m_reads < m_size), 1);
        checkOutput("rd_buf_gate", int'((reads_total - pops_total) < BUF_DEPTH), 1);
      end
      if (hs) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        log_data.push_back(out_data);
        log_last.push_back(out_last);
        pops_total++;
        if (m_beat == m_size - 1) busy_n = 1'b0;
        m_beat++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      last_rd    = fifo_rd_en;
      if (fifo_rd_en) begin
        reads_total++;
        m_reads++;
        rd_events++;
      end
      if (!m_busy) begin
        if (int'(fifo_data_count) >= BURST_LEN) begin
          busy_n = 1'b1; m_size = BURST_LEN; m_beat = 0; m_reads = 0;
        end else if (flush && fifo_data_count != '0) begin
          busy_n = 1'b1; m_size = int'(fifo_data_count); m_beat = 0; m_reads = 0;
        end
      end
      m_busy = busy_n;
    end
  end

  task automatic waitDrain(input int max_cyc, input int mode, input logic fl);
    int n = 0;
    while ((m_busy || exp_q.size() != 0) && n < max_cyc) begin
      applyStimulus(1'b0, '0, readyFor(mode), fl);
      n++;
    end
    checkOutput("drain_bound", int'(n < max_cyc), 1);
    flush = 1'b0;
  endtask

  task automatic resetCheck();
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    checkOutput("rst_rd_en", int'(fifo_rd_en), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    reset = 1'b0;
    resetCheck();

    // Full burst of 0x10..0x17 with constant ready and latency measurement.
    log_data.delete(); log_last.delete();
    cyc_cnt_hit = -1; cyc_first_valid = -1; arm_lat = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DATA_W'(8'h10 + i), 1'b1, 1'b0);
    waitDrain(200, 0, 1'b0);
    arm_lat = 1'b0;
    checkOutput("t1_beats", log_data.size(), 8);
    for (int i = 0; i < 8 && i < log_data.size(); i++) begin
      checkOutput("t1_data", int'(log_data[i]), 16 + i);
      checkOutput("t1_last", int'(log_last[i]), int'(i == 7));
    end
    checkOutput("t1_latency", cyc_first_valid - cyc_cnt_hit, 3);

    // Five words wait without flush, then leave as a short burst.
    log_data.delete(); log_last.delete();
    rd_events = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DATA_W'(8'h30 + i), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_no_read", rd_events, 0);
    waitDrain(200, 0, 1'b1);
    checkOutput("t2_beats", log_data.size(), 5);
    for (int i = 0; i < 5 && i < log_data.size(); i++) begin
      checkOutput("t2_data", int'(log_data[i]), 48 + i);
      checkOutput("t2_last", int'(log_last[i]), int'(i == 4));
    end

    // Sixteen words drained with ready toggling every cycle.
    log_data.delete(); log_last.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'(8'h20 + i), readyFor(1), 1'b0);
    waitDrain(400, 1, 1'b0);
    checkOutput("t3_beats", log_data.size(), 16);
    for (int i = 0; i < 16 && i < log_data.size(); i++) begin
      checkOutput("t3_data", int'(log_data[i]), 32 + i);
      checkOutput("t3_last", int'(log_last[i]), int'(i == 7 || i == 15));
    end

    // Slow writer: one word every third cycle.
    log_data.delete(); log_last.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, DATA_W'(8'h60 + i), 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    waitDrain(300, 0, 1'b0);
    checkOutput("t4_beats", log_data.size(), 16);
    for (int i = 0; i < 16 && i < log_data.size(); i++) begin
      checkOutput("t4_last", int'(log_last[i]), int'(i == 7 || i == 15));
    end

    // Reset two cycles into a burst, then refill for a clean burst.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DATA_W'(8'h40 + i), 1'b1, 1'b0);
    n = 0;
    while (!busy && n < 50) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("t5_busy_bound", int'(n < 50), 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    log_data.delete(); log_last.delete();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    reset = 1'b0;
    resetCheck();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DATA_W'(8'h48 + i), 1'b1, 1'b0);
    n = 0;
    while (log_data.size() < 8 && n < 200) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("t5_beats_bound", int'(n < 200), 1);
    for (int i = 0; i < 8 && i < log_data.size(); i++) begin
      checkOutput("t5_data_seq", int'(log_data[i]), int'(DATA_W'(log_data[0] + DATA_W'(i))));
      checkOutput("t5_last", int'(log_last[i]), int'(i == 7));
    end
    waitDrain(300, 0, 1'b1);

    // Single word flushed out as a one-beat burst.
    log_data.delete(); log_last.delete();
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    waitDrain(100, 0, 1'b1);
    checkOutput("t6_beats", log_data.size(), 1);
    if (log_data.size() > 0) begin
      checkOutput("t6_data", int'(log_data[0]), 8'h99);
      checkOutput("t6_last", int'(log_last[0]), 1);
    end
    checkOutput("t6_idle", int'(busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus((fifo_q.size() < FIFO_SIZE - 2) && ($urandom_range(0, 1) == 1),
                    DATA_W'($urandom), readyFor(2), ($urandom_range(0, 15) == 0));
    end
    waitDrain(2000, 2, 1'b1);
    checkOutput("final_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
